// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-lane round-robin mux arbiter.
package mux4_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned LANES = 4;
  localparam int unsigned IDXW  = 2;

  // {s0,s1} select codes per lane
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [1:0] lane_sel(input logic [IDXW-1:0] idx);
    logic [1:0] sel;
    case (idx)
      2'd0:    sel = SEL_A;
      2'd1:    sel = SEL_B;
      2'd2:    sel = SEL_C;
      default: sel = SEL_D;
    endcase
    return sel;
  endfunction

  function automatic logic [LANES-1:0] lane_onehot(input logic [IDXW-1:0] idx);
    return LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4x1_using_terinary_dut.sv
// One-bit 4:1 mux built from nested ternaries; lane index = {s0,s1}.
module mux4x1_using_terinary_dut (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic s0,
  input  logic s1,
  output logic y
);

  assign y = s0 ? (s1 ? d : c) : (s1 ? b : a);

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning upward from start_i with wrap.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [LANES-1:0] req_i,
  input  logic [IDXW-1:0]  start_i,
  output logic             found_o,
  output logic [LANES-1:0] pick_o,
  output logic [IDXW-1:0]  idx_o
);

  logic [IDXW-1:0] cand;

  // Scan in reverse so the candidate closest to start_i is written last and wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      cand = start_i + IDXW'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
    pick_o = found_o ? lane_onehot(idx_o) : '0;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux datapath with registered grant, select and data.
// Optional forced rotation after HOLD_MAX grant cycles: define MUX4_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DW       = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    gnt,
  output logic          s0,
  output logic          s1,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          busy
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e          state_q;
  logic [3:0]      gnt_q;
  logic            s0_q;
  logic            s1_q;
  logic [DW-1:0]   y_q;
  logic            y_valid_q;
  logic [IDXW-1:0] last_q;
  logic [7:0]      hold_cnt_q;

  logic [IDXW-1:0] cur_idx_c;
  logic [IDXW-1:0] base_c;
  logic [IDXW-1:0] start_c;
  logic            found_c;
  logic [3:0]      pick_c;
  logic [IDXW-1:0] pick_idx_c;
  logic [DW-1:0]   mux_y_c;
  logic            release_c;
  logic            preempt_c;
  logic [7:0]      hold_inc_c;

  assign cur_idx_c = {s0_q, s1_q};
  // Idle scans after the last served lane; a releasing grant scans after itself.
  assign base_c    = (state_q == GRANT) ? cur_idx_c : last_q;
  assign start_c   = base_c + IDXW'(1);
  assign release_c = ~req[cur_idx_c];
  assign hold_inc_c = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 8'd1;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  assign preempt_c = (hold_cnt_q == HOLD_LAST) && (|(req & ~gnt_q));
`else
  assign preempt_c = 1'b0;
`endif

  rr_pick4 u_pick (
    .req_i   (req),
    .start_i (start_c),
    .found_o (found_c),
    .pick_o  (pick_c),
    .idx_o   (pick_idx_c)
  );

  for (genvar i = 0; i < DW; i++) begin : g_mux
    mux4x1_using_terinary_dut u_mux (
      .a  (a[i]),
      .b  (b[i]),
      .c  (c[i]),
      .d  (d[i]),
      .s0 (s0_q),
      .s1 (s1_q),
      .y  (mux_y_c[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      last_q     <= IDXW'(3);
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          y_valid_q <= 1'b0;
          if (found_c) begin
            state_q      <= GRANT;
            gnt_q        <= pick_c;
            {s0_q, s1_q} <= lane_sel(pick_idx_c);
            hold_cnt_q   <= '0;
          end
        end
        GRANT: begin
          y_q       <= mux_y_c;
          y_valid_q <= 1'b1;
          if (release_c || preempt_c) begin
            last_q     <= cur_idx_c;
            hold_cnt_q <= '0;
            if (found_c) begin
              gnt_q        <= pick_c;
              {s0_q, s1_q} <= lane_sel(pick_idx_c);
            end else begin
              gnt_q        <= '0;
              {s0_q, s1_q} <= SEL_A;
              state_q      <= IDLE;
            end
          end else begin
            hold_cnt_q <= hold_inc_c;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign s0      = s0_q;
  assign s1      = s1_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == GRANT);

endmodule
